// File: rtl/pilha_param_if.sv
// rtl/pilha_param_if.sv - request/data bundle between the control unit/ALU and the operand stack
//
// Purpose: groups the stack requests, push data and stack views into one port.
// Signals:
//   push, pop, swap, clr_err, controle_pilha : requests and push-source select
//   din_UC [DATA_W], din_ULA [ULA_W]         : push data candidates
//   dout, tos, nos [DATA_W]                   : popped word, top and next-on-stack
//   count [CNT_W], full, empty                : occupancy
//   overflow, underflow                       : sticky error flags
// Modports: master = control unit side, slave = stack side.
interface pilha_param_if #(
  parameter int DATA_W = 16,
  parameter int ULA_W  = 32,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = $clog2(DEPTH + 1)
);
  logic              push;
  logic              pop;
  logic              swap;
  logic              clr_err;
  logic              controle_pilha;
  logic [DATA_W-1:0] din_UC;
  logic [ULA_W-1:0]  din_ULA;
  logic [DATA_W-1:0] dout;
  logic [DATA_W-1:0] tos;
  logic [DATA_W-1:0] nos;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;
  logic              overflow;
  logic              underflow;

  modport master (
    output push, pop, swap, clr_err, controle_pilha, din_UC, din_ULA,
    input  dout, tos, nos, count, full, empty, overflow, underflow
  );

  modport slave (
    input  push, pop, swap, clr_err, controle_pilha, din_UC, din_ULA,
    output dout, tos, nos, count, full, empty, overflow, underflow
  );
endinterface

// File: rtl/pilha_param.sv
// rtl/pilha_param.sv - parametrised LIFO operand stack with replace-top, swap and sticky errors
//
// Purpose: DEPTH-entry stack of DATA_W-bit words fed from the control unit or
// the truncated ALU result.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-low reset (clears count, dout and error flags)
//   bus : pilha_param_if.slave (requests, push data, views, occupancy, flags)
module pilha_param #(
  parameter int DATA_W = 16,
  parameter int ULA_W  = 32,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst,
  pilha_param_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  // Storage is deliberately left out of reset; count alone defines validity.
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  logic              full_w, empty_w;
  logic [PTR_W-1:0]  top_idx, nos_idx, wr_idx;
  logic [DATA_W-1:0] push_data, tos_w, nos_w;
  logic              wr_en, swap_en, ovf_set, unf_set;

  // ALU result is truncated, never saturated.
  assign push_data = bus.controle_pilha ? bus.din_ULA[DATA_W-1:0] : bus.din_UC;

  generate
    if (ULA_W > DATA_W) begin : g_ula_hi
      logic unused_ula_hi;
      assign unused_ula_hi = ^bus.din_ULA[ULA_W-1:DATA_W];
    end
  endgenerate

  assign full_w  = (count_q == DEPTH_C);
  assign empty_w = (count_q == '0);

  // Indices wrap harmlessly when count is too small; the views mask them out.
  assign top_idx = PTR_W'(count_q - CNT_W'(1));
  assign nos_idx = PTR_W'(count_q - CNT_W'(2));

  assign tos_w = empty_w ? '0 : mem_q[top_idx];
  assign nos_w = (count_q < CNT_W'(2)) ? '0 : mem_q[nos_idx];

  always_comb begin
    count_d = count_q;
    dout_d  = dout_q;
    wr_en   = 1'b0;
    wr_idx  = top_idx;
    swap_en = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;

    unique case ({bus.push, bus.pop})
      2'b10: begin
        if (!full_w) begin
          wr_en   = 1'b1;
          wr_idx  = PTR_W'(count_q);
          count_d = count_q + CNT_W'(1);
        end else begin
          ovf_set = 1'b1;
        end
      end
      2'b01: begin
        if (!empty_w) begin
          dout_d  = tos_w;
          count_d = count_q - CNT_W'(1);
        end else begin
          unf_set = 1'b1;
        end
      end
      2'b11: begin
        // Replace top: legal even when full. On empty it degrades to a push
        // but still flags the missing pop operand.
        wr_en = 1'b1;
        if (!empty_w) begin
          dout_d = tos_w;
          wr_idx = top_idx;
        end else begin
          wr_idx  = '0;
          count_d = CNT_W'(1);
          unf_set = 1'b1;
        end
      end
      default: begin
        if (bus.swap) begin
          if (count_q >= CNT_W'(2)) begin
            swap_en = 1'b1;
          end else begin
            unf_set = 1'b1;
          end
        end
      end
    endcase

    // A new error in the clearing cycle keeps the flag set.
    ovf_d = ovf_set | (ovf_q & ~bus.clr_err);
    unf_d = unf_set | (unf_q & ~bus.clr_err);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      dout_q  <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      dout_q  <= dout_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_idx] <= push_data;
    end else if (swap_en) begin
      mem_q[top_idx] <= nos_w;
      mem_q[nos_idx] <= tos_w;
    end
  end

  assign bus.dout      = dout_q;
  assign bus.tos       = tos_w;
  assign bus.nos       = nos_w;
  assign bus.count     = count_q;
  assign bus.full      = full_w;
  assign bus.empty     = empty_w;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
endmodule
